// File: rtl/vic_reg_pkg.sv
// Shared types and defaults for the VIC-II register initiator.
// Phase timing is expressed in clk_dot4x ticks within one phi half-cycle.
package vic_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACTIVE,
        RESP
    } state_e;

    localparam int PHI_HALF_TICKS  = 16;
    localparam int TICK_W          = $clog2(PHI_HALF_TICKS);
    localparam int DEF_SAMPLE_TICK = 12;
    localparam int DEF_STALL_LIMIT = 255;
    localparam int DEF_BA_GRACE    = 3;

endpackage

// File: rtl/vic_reg_initiator_if.sv
// Command/response handshake plus the ce/rw/adl/dbl bus of the VIC-II.
// master is the initiator; slave is the VIC plus the command source.
interface vic_reg_initiator_if;

    logic       clk_phi;
    logic       aec;
    logic       ba;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic       ce;
    logic       rw;
    logic [5:0] adl_o;
    logic       adl_oe;
    logic [7:0] dbl_o;
    logic       dbl_oe;
    logic [7:0] dbl_i;

    modport master (
        input  clk_phi, aec, ba,
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  dbl_i,
        output cmd_ready,
        output rsp_valid, rsp_err, rsp_rdata,
        output ce, rw, adl_o, adl_oe, dbl_o, dbl_oe
    );

    modport slave (
        output clk_phi, aec, ba,
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output dbl_i,
        input  cmd_ready,
        input  rsp_valid, rsp_err, rsp_rdata,
        input  ce, rw, adl_o, adl_oe, dbl_o, dbl_oe
    );

endinterface

// File: rtl/phi_edge_tracker.sv
// Synchronises phi2, flags its edges, counts ticks into phi-high
// and counts phi cycles seen with ba low (saturating).
module phi_edge_tracker
    import vic_reg_pkg::*;
#(
    parameter int BA_GRACE = DEF_BA_GRACE,
    parameter int BA_W     = $clog2(DEF_BA_GRACE + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_phi,
    input  logic              ba,
    output logic              rise_tick,
    output logic              fall_tick,
    output logic [TICK_W-1:0] tick_cnt,
    output logic [BA_W-1:0]   ba_cnt
);

    logic              phi_q;
    logic              phi_qq;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic [BA_W-1:0]   ba_cnt_q;
    logic [BA_W-1:0]   ba_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi_q      <= 1'b0;
            phi_qq     <= 1'b0;
            tick_cnt_q <= '0;
            ba_cnt_q   <= '0;
        end else begin
            phi_q      <= clk_phi;
            phi_qq     <= phi_q;
            tick_cnt_q <= tick_cnt_d;
            ba_cnt_q   <= ba_cnt_d;
        end
    end

    assign rise_tick = phi_q & ~phi_qq;
    assign fall_tick = ~phi_q & phi_qq;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (rise_tick) begin
            tick_cnt_d = '0;
        end else if (phi_q) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
        ba_cnt_d = ba_cnt_q;
        if (ba) begin
            ba_cnt_d = '0;
        end else if (rise_tick && ba_cnt_q < BA_W'(BA_GRACE)) begin
            ba_cnt_d = ba_cnt_q + 1'b1;
        end
    end

    assign tick_cnt = tick_cnt_q;
    assign ba_cnt   = ba_cnt_q;

endmodule

// File: rtl/vic_reg_initiator.sv
// 6510-side initiator: one VIC-II register access per phi2-high phase,
// gated by aec/ba, with stall timeout and a one-cycle response strobe.
module vic_reg_initiator
    import vic_reg_pkg::*;
#(
    parameter int SAMPLE_TICK = DEF_SAMPLE_TICK,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int BA_GRACE    = DEF_BA_GRACE
) (
    input  logic                clk_dot4x,
    input  logic                rst_n,
    vic_reg_initiator_if.master bus
);

    localparam int BA_W = $clog2(BA_GRACE + 2);
    localparam int ST_W = $clog2(STALL_LIMIT + 2);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [5:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ST_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic              ready_q, ready_d;
    logic              ce_q, ce_d;
    logic              rw_q, rw_d;
    logic [5:0]        adl_o_q, adl_o_d;
    logic              adl_oe_q, adl_oe_d;
    logic [7:0]        dbl_o_q, dbl_o_d;
    logic              dbl_oe_q, dbl_oe_d;

    logic              rise_tick;
    logic              fall_tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [BA_W-1:0]   ba_cnt;
    logic              eligible;
    logic [ST_W-1:0]   stall_inc;
    logic              stall_hit;
    logic              act;

    phi_edge_tracker #(
        .BA_GRACE (BA_GRACE),
        .BA_W     (BA_W)
    ) u_phi (
        .clk       (clk_dot4x),
        .rst_n     (rst_n),
        .clk_phi   (bus.clk_phi),
        .ba        (bus.ba),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .tick_cnt  (tick_cnt),
        .ba_cnt    (ba_cnt)
    );

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            ready_q     <= 1'b0;
            ce_q        <= 1'b1;
            rw_q        <= 1'b1;
            adl_o_q     <= '0;
            adl_oe_q    <= 1'b0;
            dbl_o_q     <= '0;
            dbl_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            ready_q     <= ready_d;
            ce_q        <= ce_d;
            rw_q        <= rw_d;
            adl_o_q     <= adl_o_d;
            adl_oe_q    <= adl_oe_d;
            dbl_o_q     <= dbl_o_d;
            dbl_oe_q    <= dbl_oe_d;
        end
    end

    // Writes ride through the first BA_GRACE phi cycles after ba falls.
    assign eligible  = bus.aec & (we_q ? (bus.ba | (ba_cnt < BA_W'(BA_GRACE)))
                                       : bus.ba);
    assign stall_inc = stall_cnt_q + 1'b1;
    assign stall_hit = stall_inc >= ST_W'(STALL_LIMIT);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    we_d        = bus.cmd_we;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    stall_cnt_d = '0;
                    state_d     = ARM;
                end
            end
            ARM: begin
                if (rise_tick) begin
                    if (eligible) begin
                        state_d = ACTIVE;
                    end else begin
                        stall_cnt_d = stall_inc;
                        if (stall_hit) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                    end
                end
            end
            ACTIVE: begin
                if (!bus.aec) begin
                    rdata_d     = '0;
                    stall_cnt_d = stall_inc;
                    err_d       = stall_hit;
                    state_d     = stall_hit ? RESP : ARM;
                end else begin
                    if (!we_q && tick_cnt == TICK_W'(SAMPLE_TICK)) begin
                        rdata_d = bus.dbl_i;
                    end
                    if (fall_tick) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus flops follow the next state, so they move only on transitions.
    always_comb begin
        act      = (state_d == ACTIVE);
        ready_d  = (state_d == IDLE);
        ce_d     = ~act;
        rw_d     = ~(act & we_q);
        adl_oe_d = act;
        adl_o_d  = act ? addr_q : 6'h00;
        dbl_oe_d = act & we_q;
        dbl_o_d  = dbl_oe_d ? wdata_q : 8'h00;
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = bus.rsp_valid & err_q;
    assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : 8'h00;
    assign bus.ce        = ce_q;
    assign bus.rw        = rw_q;
    assign bus.adl_o     = adl_o_q;
    assign bus.adl_oe    = adl_oe_q;
    assign bus.dbl_o     = dbl_o_q;
    assign bus.dbl_oe    = dbl_oe_q;

endmodule

// File: tb/tb_vic_reg_initiator.sv
// Directed bench for vic_reg_initiator with a small VIC-side bus model.
// phi2 runs 16 dot4x ticks high / 16 low, free-running.
module tb_vic_reg_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         lo_cnt = 0;
    int         bad_cnt = 0;
    int         rsp_cnt = 0;
    int         ce_run = 0;
    logic       mon_we = 1'b0;
    logic [5:0] mon_addr = '0;
    logic [7:0] mon_wdata = '0;
    logic       got, err;
    logic [7:0] rd;
    int         lat;

    vic_reg_initiator_if bus();

    vic_reg_initiator #(.STALL_LIMIT(4)) dut (
        .clk_dot4x (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.clk_phi = 1'b0;
        forever begin
            repeat (16) @(posedge clk);
            #1 bus.clk_phi = ~bus.clk_phi;
        end
    end

    // VIC drives read data only late in the access window.
    always @(posedge clk) ce_run <= bus.ce ? 0 : ce_run + 1;

    assign bus.dbl_i = (!bus.ce && bus.rw && ce_run >= 10 && ce_run <= 14)
                     ? ((bus.adl_o == 6'h12) ? 8'h9B
                                             : ({2'b00, bus.adl_o} ^ 8'hA5))
                     : 8'hFF;

    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_cnt++;
        if (!bus.ce) begin
            lo_cnt++;
            if (bus.rw !== !mon_we || bus.adl_oe !== 1'b1
                || bus.adl_o !== mon_addr) bad_cnt++;
            if (mon_we && (bus.dbl_oe !== 1'b1 || bus.dbl_o !== mon_wdata))
                bad_cnt++;
            if (!mon_we && bus.dbl_oe !== 1'b0) bad_cnt++;
        end else if (bus.adl_oe || bus.dbl_oe || !bus.rw) begin
            bad_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic we, input logic [5:0] a,
                           input logic [7:0] d, input int budget,
                           output logic o_got, output logic o_err,
                           output logic [7:0] o_rd, output int o_lat);
        int n;
        lo_cnt = 0;
        bad_cnt = 0;
        rsp_cnt = 0;
        mon_we = we;
        mon_addr = a;
        mon_wdata = d;
        o_got = 1'b0;
        o_err = 1'b0;
        o_rd = '0;
        o_lat = 0;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_we = we;
        bus.cmd_addr = a;
        bus.cmd_wdata = d;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        while (!o_got && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) begin
                o_got = 1'b1;
                o_err = bus.rsp_err;
                o_rd = bus.rsp_rdata;
                o_lat = n;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_ce_low();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ce && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_wdata = '0;
        bus.aec = 1'b1;
        bus.ba = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctl", {bus.ce, bus.rw, bus.adl_oe, bus.dbl_oe,
                          bus.cmd_ready, bus.rsp_valid, bus.rsp_err},
              7'b1100000);
        check("rst_adl", bus.adl_o, 0);
        check("rst_dbl", bus.dbl_o, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        #1 check("ready_pre", bus.cmd_ready, 0);
        @(posedge clk);
        #1 check("ready_rise", bus.cmd_ready, 1);

        run_cmd(1'b1, 6'h20, 8'h0E, 67, got, err, rd, lat);
        check("wr_got", got, 1);
        check("wr_err", err, 0);
        check("wr_rdata", rd, 0);
        check("wr_ce_lo", lo_cnt, 16);
        check("wr_bus", bad_cnt, 0);
        check("wr_rsp1", rsp_cnt, 1);

        run_cmd(1'b0, 6'h12, 8'h00, 67, got, err, rd, lat);
        check("rd_got", got, 1);
        check("rd_err", err, 0);
        check("rd_data", rd, 8'h9B);
        check("rd_ce_lo", lo_cnt, 16);
        check("rd_bus", bad_cnt, 0);

        run_cmd(1'b0, 6'h2F, 8'h00, 67, got, err, rd, lat);
        check("rd2_data", rd, 8'h8A);
        check("rd2_rsp1", rsp_cnt, 1);

        bus.ba = 1'b0;
        fork
            run_cmd(1'b0, 6'h12, 8'h00, 300, got, err, rd, lat);
            begin
                repeat (80) @(negedge clk);
                bus.ba = 1'b1;
            end
        join
        check("bard_got", got, 1);
        check("bard_err", err, 0);
        check("bard_data", rd, 8'h9B);
        check("bard_held", lat > 80, 1);
        check("bard_ce_lo", lo_cnt, 16);

        @(posedge bus.clk_phi);
        repeat (4) @(negedge clk);
        bus.ba = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cmd(1'b1, 6'h18, 8'h30 + 8'(i), 67, got, err, rd, lat);
            check($sformatf("bawr%0d_got", i), got, 1);
            check($sformatf("bawr%0d_err", i), err, 0);
            check($sformatf("bawr%0d_ce_lo", i), lo_cnt, 16);
        end
        run_cmd(1'b1, 6'h18, 8'h55, 200, got, err, rd, lat);
        check("bawr3_got", got, 1);
        check("bawr3_err", err, 1);
        check("bawr3_ce_lo", lo_cnt, 0);
        bus.ba = 1'b1;

        bus.aec = 1'b0;
        run_cmd(1'b0, 6'h12, 8'h00, 200, got, err, rd, lat);
        check("to_got", got, 1);
        check("to_err", err, 1);
        check("to_rdata", rd, 0);
        check("to_ce_lo", lo_cnt, 0);
        check("to_lat", lat >= 98 && lat <= 129, 1);
        bus.aec = 1'b1;

        fork
            run_cmd(1'b1, 6'h3F, 8'hC3, 150, got, err, rd, lat);
            begin
                wait_ce_low();
                repeat (5) @(negedge clk);
                bus.aec = 1'b0;
                @(negedge clk);
                check("drop_rel", {bus.ce, bus.adl_oe, bus.dbl_oe, bus.rw},
                      4'b1001);
                bus.aec = 1'b1;
            end
        join
        check("drop_got", got, 1);
        check("drop_err", err, 0);
        check("drop_ce_lo", lo_cnt, 22);
        check("drop_bus", bad_cnt, 0);

        fork
            run_cmd(1'b0, 6'h12, 8'h00, 90, got, err, rd, lat);
            begin
                wait_ce_low();
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("arst_ctl", {bus.ce, bus.rw, bus.adl_oe, bus.dbl_oe,
                                   bus.cmd_ready, bus.rsp_valid}, 6'b110000);
                check("arst_adl", bus.adl_o, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check("arst_norsp", got, 0);
        check("arst_rspcnt", rsp_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
